// File: rtl/cam_entry_writer_pkg.sv
// Shared definitions for the CAM entry writer: stream word width, entry length
// derivation and the writer FSM states.
package cam_entry_writer_pkg;

  localparam int WORD_WIDTH = 32;

  function automatic int calc_n_words(input int c_width);
    return (c_width + WORD_WIDTH - 1) / WORD_WIDTH;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    ISSUE,
    WAIT
  } state_t;

endpackage

// File: rtl/cam_entry_writer.sv
// Assembles a CAM entry from a stream of config words and issues exactly one
// write into the CAM, honouring the CAM's BUSY handshake.
module cam_entry_writer
  import cam_entry_writer_pkg::*;
#(
  parameter int C_WIDTH   = 205,
  parameter int ADDR_BITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic [ADDR_BITS-1:0]  s_addr,
  input  logic                  s_last,
  output logic                  WE,
  output logic [ADDR_BITS-1:0]  WR_ADDR,
  output logic [C_WIDTH-1:0]    DIN,
  input  logic                  BUSY,
  output logic                  done,
  output logic                  err
);

  localparam int N_WORDS = calc_n_words(C_WIDTH);
  localparam int CNT_W   = $clog2(N_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_WORDS);

  state_t                 state, next_state;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   xfer;

  // The final word is only ever consumed on its own s_last transfer, so it goes
  // straight from s_data into DIN and never needs a slot of its own.
  logic [WORD_WIDTH-1:0]             slots [N_WORDS-1];
  logic [(N_WORDS-1)*WORD_WIDTH-1:0] head;

  assign xfer = s_valid && s_ready;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    WE         = 1'b0;
    case (state)
      IDLE: next_state = COLLECT;
      COLLECT: begin
        s_ready = 1'b1;
        if (s_valid && s_last && cnt == LAST_CNT) next_state = ISSUE;
      end
      ISSUE: begin
        if (!BUSY) begin
          WE         = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (!BUSY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < N_WORDS - 1; i++) head[i*WORD_WIDTH +: WORD_WIDTH] = slots[i];
  end

  always_ff @(posedge CLK) begin
    if (xfer && cnt < LAST_CNT) slots[cnt] <= s_data;
  end

  // WR_ADDR/DIN are committed on the accepted s_last, so they stay frozen
  // through ISSUE and WAIT and survive dropped entries untouched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      addr_q  <= '0;
      WR_ADDR <= '0;
      DIN     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= (state == WAIT) && !BUSY;
      err  <= 1'b0;
      if (xfer) begin
        if (cnt == '0) addr_q <= s_addr;
        if (s_last) begin
          cnt <= '0;
          if (cnt == LAST_CNT) begin
            WR_ADDR <= addr_q;
            DIN     <= C_WIDTH'({s_data, head});
          end else begin
            err <= 1'b1;
          end
        end else if (cnt != FULL_CNT) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_entry_writer.sv
// Directed bench for cam_entry_writer: a table of entries with hand-chosen
// BUSY profiles, plus hand-written reset and back-to-back sequences.
module tb_cam_entry_writer;

  localparam int C_WIDTH   = 205;
  localparam int ADDR_BITS = 4;
  localparam int N_WORDS   = 7;

  typedef logic [C_WIDTH-1:0] wide_t;

  typedef struct {
    int          n_words;
    logic [31:0] base;
    logic [3:0]  addr;
    int          busy_pre;
    int          busy_post;
    bit          exp_we;
  } vec_t;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 s_valid;
  logic                 s_ready;
  logic [31:0]          s_data;
  logic [ADDR_BITS-1:0] s_addr;
  logic                 s_last;
  logic                 WE;
  logic [ADDR_BITS-1:0] WR_ADDR;
  logic [C_WIDTH-1:0]   DIN;
  logic                 BUSY;
  logic                 done;
  logic                 err;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    we_total = 0;
  int    done_total = 0;
  int    err_total = 0;
  wide_t we_din_log [16];
  logic [3:0] we_addr_log [16];
  wide_t exp_din_cur;
  logic [3:0] exp_addr_cur;
  vec_t  vecs [8];

  cam_entry_writer #(.C_WIDTH(C_WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_addr(s_addr), .s_last(s_last),
    .WE(WE), .WR_ADDR(WR_ADDR), .DIN(DIN), .BUSY(BUSY),
    .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse counters and a log of every write the CAM would see.
  always @(negedge CLK) begin
    if (WE) begin
      we_din_log[we_total[3:0]]  = DIN;
      we_addr_log[we_total[3:0]] = WR_ADDR;
      we_total = we_total + 1;
    end
    if (done) done_total = done_total + 1;
    if (err)  err_total  = err_total + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic wide_t model_din(input logic [31:0] base);
    logic [N_WORDS*32-1:0] full;
    for (int i = 0; i < N_WORDS; i++) full[i*32 +: 32] = base + 32'(i);
    return wide_t'(full);
  endfunction

  task automatic checkOutput(input string name, input wide_t actual, input wide_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Offers one word and holds it until accepted; returns the stalled cycles.
  task automatic push_word(input logic [31:0] data, input logic [3:0] addr, input logic last,
                           output int stalls);
    bit got;
    got    = 1'b0;
    stalls = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_addr  = addr;
    s_last  = last;
    for (int i = 0; i < 50 && !got; i++) begin
      got = s_ready;
      if (!got) stalls++;
      @(posedge CLK); #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: got s_ready=0 for 50 cycles, expected acceptance");
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int st, we0, done0, err0, we_k, done_k, err_k, ready_bad, ready_after;
    wide_t din_at_we;
    logic [3:0] addr_at_we;
    we0 = we_total; done0 = done_total; err0 = err_total;
    we_k = -1; done_k = -1; err_k = -1; ready_bad = 0; ready_after = -1;
    din_at_we = '0; addr_at_we = '0;
    BUSY = (v.busy_pre > 0);
    for (int w = 0; w < v.n_words; w++)
      push_word(v.base + 32'(w), v.addr, (w == v.n_words - 1), st);
    s_valid = 1'b0;
    s_last  = 1'b0;
    // k counts cycles after the one that accepted s_last.
    for (int k = 1; k <= 12 + v.busy_pre + v.busy_post; k++) begin
      if (we_k < 0) BUSY = (k <= v.busy_pre);
      else          BUSY = (k <= we_k + v.busy_post);
      @(negedge CLK);
      if (WE && we_k < 0) begin
        we_k = k; din_at_we = DIN; addr_at_we = WR_ADDR;
      end
      if (done && done_k < 0) done_k = k;
      if (err && err_k < 0) err_k = k;
      if (v.exp_we) begin
        if (done_k < 0 || k == done_k) begin
          if (s_ready) ready_bad++;
        end else if (k == done_k + 1) begin
          ready_after = int'(s_ready);
        end
      end else if (!s_ready) begin
        ready_bad++;
      end
      @(posedge CLK); #1;
    end
    BUSY = 1'b0;
    checkOutput($sformatf("v%0d_we_count", idx), wide_t'(we_total - we0), wide_t'(v.exp_we ? 1 : 0));
    checkOutput($sformatf("v%0d_done_count", idx), wide_t'(done_total - done0), wide_t'(v.exp_we ? 1 : 0));
    checkOutput($sformatf("v%0d_err_count", idx), wide_t'(err_total - err0), wide_t'(v.exp_we ? 0 : 1));
    checkOutput($sformatf("v%0d_ready_backpressure", idx), wide_t'(ready_bad), wide_t'(0));
    if (v.exp_we) begin
      exp_din_cur  = model_din(v.base);
      exp_addr_cur = v.addr;
      checkOutput($sformatf("v%0d_we_latency", idx), wide_t'(we_k), wide_t'(v.busy_pre + 1));
      checkOutput($sformatf("v%0d_done_latency", idx), wide_t'(done_k), wide_t'(we_k + v.busy_post + 2));
      checkOutput($sformatf("v%0d_din_at_we", idx), din_at_we, exp_din_cur);
      checkOutput($sformatf("v%0d_addr_at_we", idx), wide_t'(addr_at_we), wide_t'(exp_addr_cur));
      checkOutput($sformatf("v%0d_ready_after_done", idx), wide_t'(ready_after), wide_t'(1));
    end else begin
      checkOutput($sformatf("v%0d_err_latency", idx), wide_t'(err_k), wide_t'(1));
    end
    checkOutput($sformatf("v%0d_din_hold", idx), DIN, exp_din_cur);
    checkOutput($sformatf("v%0d_addr_hold", idx), wide_t'(WR_ADDR), wide_t'(exp_addr_cur));
  endtask

  initial begin
    int st, stalls, we0, done0, err0;
    vec_t fresh;

    vecs[0] = '{7, 32'h0000_0001, 4'd5,  0, 0, 1'b1};
    vecs[1] = '{7, 32'hA000_0000, 4'd9,  4, 3, 1'b1};
    vecs[2] = '{3, 32'h0000_0100, 4'd3,  0, 0, 1'b0};
    vecs[3] = '{7, 32'h0000_0200, 4'd2,  0, 0, 1'b1};
    vecs[4] = '{9, 32'h0000_0300, 4'd7,  0, 0, 1'b0};
    vecs[5] = '{1, 32'h0000_0400, 4'd1,  0, 0, 1'b0};
    vecs[6] = '{8, 32'h0000_0600, 4'd4,  0, 0, 1'b0};
    vecs[7] = '{7, 32'hFFFF_FFF0, 4'd0,  1, 1, 1'b1};

    RST = 1'b1; s_valid = 1'b0; s_data = '0; s_addr = '0; s_last = 1'b0; BUSY = 1'b0;
    exp_din_cur = '0; exp_addr_cur = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_s_ready", wide_t'(s_ready), wide_t'(0));
    checkOutput("rst_we", wide_t'(WE), wide_t'(0));
    checkOutput("rst_wr_addr", wide_t'(WR_ADDR), wide_t'(0));
    checkOutput("rst_din", DIN, wide_t'(0));
    checkOutput("rst_done", wide_t'(done), wide_t'(0));
    checkOutput("rst_err", wide_t'(err), wide_t'(0));
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("rst_release_ready_low", wide_t'(s_ready), wide_t'(0));
    @(posedge CLK); #1;
    checkOutput("rst_release_ready_high", wide_t'(s_ready), wide_t'(1));

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i);
      if (i == 0) begin
        checkOutput("t1_din_lo", wide_t'(DIN[31:0]), wide_t'(32'h0000_0001));
        checkOutput("t1_din_hi", wide_t'(DIN[204:192]), wide_t'(13'h0007));
        checkOutput("t1_wr_addr", wide_t'(WR_ADDR), wide_t'(4'd5));
      end
    end

    // Reset in the middle of an entry must abandon it without a write.
    we0 = we_total; done0 = done_total; err0 = err_total;
    for (int w = 0; w < 4; w++) push_word(32'h0000_0500 + 32'(w), 4'd6, 1'b0, st);
    s_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    checkOutput("midrst_ready", wide_t'(s_ready), wide_t'(0));
    RST = 1'b0;
    exp_din_cur = '0;
    exp_addr_cur = '0;
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("midrst_we_count", wide_t'(we_total - we0), wide_t'(0));
    checkOutput("midrst_done_count", wide_t'(done_total - done0), wide_t'(0));
    checkOutput("midrst_err_count", wide_t'(err_total - err0), wide_t'(0));
    checkOutput("midrst_din_cleared", DIN, wide_t'(0));
    checkOutput("midrst_ready_back", wide_t'(s_ready), wide_t'(1));
    fresh = '{7, 32'h1234_0000, 4'd15, 0, 0, 1'b1};
    applyStimulus(fresh, 8);

    // Two entries with s_valid held high across the gap between them.
    we0 = we_total; done0 = done_total; err0 = err_total;
    stalls = 0;
    BUSY = 1'b0;
    for (int e = 0; e < 2; e++) begin
      for (int w = 0; w < N_WORDS; w++) begin
        push_word((e == 0 ? 32'hC000_0000 : 32'hD000_0010) + 32'(w), (e == 0 ? 4'd11 : 4'd12),
                  (w == N_WORDS - 1), st);
        stalls += st;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    checkOutput("b2b_we_count", wide_t'(we_total - we0), wide_t'(2));
    checkOutput("b2b_done_count", wide_t'(done_total - done0), wide_t'(2));
    checkOutput("b2b_err_count", wide_t'(err_total - err0), wide_t'(0));
    checkOutput("b2b_stall_cycles", wide_t'(stalls), wide_t'(3));
    checkOutput("b2b_din0", we_din_log[we0[3:0]], model_din(32'hC000_0000));
    checkOutput("b2b_addr0", wide_t'(we_addr_log[we0[3:0]]), wide_t'(4'd11));
    checkOutput("b2b_din1", we_din_log[4'(we0 + 1)], model_din(32'hD000_0010));
    checkOutput("b2b_addr1", wide_t'(we_addr_log[4'(we0 + 1)]), wide_t'(4'd12));
    checkOutput("b2b_din_hold", DIN, model_din(32'hD000_0010));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
